key_debounce: RTL

Four-channel push-button conditioner that sits directly upstream of `key_led`. It synchronises the raw, active-low board keys into `sys_clk` and rejects contact bounce with a per-key stability counter. It then presents a clean debounced level plus single-cycle press and release strobes. `key_led` consumes `key_value` in place of the raw `key` bus.

---
 rtl/key_debounce.sv | 72 +++++++
 1 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key two-flop synchroniser and stability-counter debouncer with press/release strobes
module key_debounce #(
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_value,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] r_sync1;
    logic [KEY_W-1:0] r_sync2;

    // Idle level of an active-low key is 1, so the synchroniser resets high
    // to avoid a phantom press straight out of reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             r_value;
        logic             r_press;
        logic             r_release;
        logic             w_differs;
        logic             w_terminal;

        assign w_differs  = r_sync2[g] != r_value;
        assign w_terminal = r_cnt == TERM_CNT;

        // Any return to the accepted level restarts the count, so only an
        // uninterrupted run of DEBOUNCE_CYCLES mismatching samples is accepted.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_cnt     <= '0;
                r_value   <= 1'b1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_terminal) begin
                    r_cnt     <= '0;
                    r_value   <= r_sync2[g];
                    r_press   <= ~r_sync2[g];
                    r_release <= r_sync2[g];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign key_value[g]   = r_value;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
    end

endmodule
